adc_chan_mux: RTL and testbench

- Transmit-side counterpart of the ADC channel splitter.
- Accepts paired channel A/B samples over a valid/ready handshake and buffers them in a small FIFO.
- Drives them out on a single shared, time-multiplexed sample bus: channel A, then channel B, one word per enabled clock.
- Feeds the DAC path and acts as a loopback source for the ADC splitter in the bench.

---
 rtl/adc_chan_mux_pkg.sv | 17 +
 rtl/adc_chan_mux_sync_fifo.sv | 70 +++++++
 rtl/adc_chan_mux.sv | 134 +++++++++++++
 tb/tb_adc_chan_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_chan_mux_pkg.sv
// Shared ADC/DAC definitions used by the channel mux (and its splitter peer).
//   PH_A / PH_B        : read-side phase encoding (A word, then B word)
//   state_e            : streaming FSM state {IDLE, RUN}
//   ADC_DATA_WIDTH     : default sample width in bits
package adc_chan_mux_pkg;

   localparam logic PH_A = 1'b0;
   localparam logic PH_B = 1'b1;

   localparam int ADC_DATA_WIDTH = 12;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : adc_chan_mux_pkg

// File: rtl/adc_chan_mux_sync_fifo.sv
// sync_fifo: parameterised single-clock FIFO with occupancy count.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   push_i, wdata_i  : write request and data (ignored when full)
//   pop_i, rdata_o   : read request (ignored when empty); rdata_o shows the head
//   full_o, empty_o  : status, decoded from the registered level
//   level_o          : current occupancy in entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule : sync_fifo

// File: rtl/adc_chan_mux.sv
// adc_chan_mux: buffers paired A/B samples and time-multiplexes them onto one
// bus, A then B, one word per enabled clock.
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   ce_i                 : output-side enable; low forces the bus idle (zeros)
//   a_i, b_i, valid_i    : input sample pair
//   ready_o              : pair accepted when valid_i && ready_o at a clock edge
//   data_o, sel_o        : mux bus and channel tag (0 = A, 1 = B)
//   frame_o              : pulse with each A slot
//   underflow_o, clr_i   : sticky empty-at-frame flag and its synchronous clear
//   level_o              : FIFO occupancy in pairs
// Handshake: ready_o depends only on registered FIFO level, so a pop in the
// same cycle never opens a full FIFO; a pushed pair is popped one edge later
// at the earliest.
module adc_chan_mux
   import adc_chan_mux_pkg::*;
#(
   parameter int DATA_WIDTH = ADC_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    ce_i,
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    sel_o,
   output logic                    frame_o,
   output logic                    underflow_o,
   input  logic                    clr_i,
   output logic [$clog2(DEPTH):0]  level_o
);

   logic [2*DATA_WIDTH-1:0] head;
   logic                    fifo_full, fifo_empty;
   logic                    push, pop;

   state_e                  state_q, state_d;
   logic                    ph_q, ph_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    sel_q, sel_d;
   logic                    frame_q, frame_d;
   logic                    uf_q, uf_d;
   logic                    uf_set;

   assign ready_o = !fifo_full;
   assign push    = valid_i && ready_o;

   sync_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .wdata_i ({a_i, b_i}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM next state: the stream starts at the first pop, ends when disabled
   always_comb begin
      state_d = state_q;
      if (!ce_i)    state_d = IDLE;
      else if (pop) state_d = RUN;
   end

   // Outputs / datapath next values
   always_comb begin
      pop     = 1'b0;
      uf_set  = 1'b0;
      ph_d    = ph_q;
      hold_d  = hold_q;
      data_d  = '0;
      sel_d   = 1'b0;
      frame_d = 1'b0;
      if (!ce_i) begin
         ph_d = PH_A;
      end else if (ph_q == PH_A) begin
         frame_d = 1'b1;
         ph_d    = PH_B;
         if (!fifo_empty) begin
            pop    = 1'b1;
            data_d = head[2*DATA_WIDTH-1:DATA_WIDTH];
            hold_d = head[DATA_WIDTH-1:0];
         end else begin
            // Empty frame: emit zeros; only an established stream flags it.
            hold_d = '0;
            uf_set = (state_q == RUN);
         end
      end else begin
         data_d = hold_q;
         sel_d  = 1'b1;
         ph_d   = PH_A;
      end
      // Set has priority over a simultaneous clear.
      uf_d = uf_set ? 1'b1 : (clr_i ? 1'b0 : uf_q);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ph_q    <= PH_A;
         hold_q  <= '0;
         data_q  <= '0;
         sel_q   <= 1'b0;
         frame_q <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         ph_q    <= ph_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
         uf_q    <= uf_d;
      end
   end

   assign data_o      = data_q;
   assign sel_o       = sel_q;
   assign frame_o     = frame_q;
   assign underflow_o = uf_q;

endmodule : adc_chan_mux

// File: tb/tb_adc_chan_mux.sv
// Bench for adc_chan_mux: directed steps followed by a loopback pass and a
// random pass, checked against a queue-based behavioural model.
module tb_adc_chan_mux;
   import adc_chan_mux_pkg::*;

   localparam int W = 12;
   localparam int D = 4;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          ce, valid, clr;
   logic [W-1:0]  a, b;
   logic          ready_o, sel_o, frame_o, underflow_o;
   logic [W-1:0]  data_o;
   logic [$clog2(D):0] level_o;

   always #5 clk = ~clk;

   adc_chan_mux #(.DATA_WIDTH(W), .DEPTH(D)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .ce_i        (ce),
      .a_i         (a),
      .b_i         (b),
      .valid_i     (valid),
      .ready_o     (ready_o),
      .data_o      (data_o),
      .sel_o       (sel_o),
      .frame_o     (frame_o),
      .underflow_o (underflow_o),
      .clr_i       (clr),
      .level_o     (level_o)
   );

   // ---------------- model state ----------------
   logic [2*W-1:0] m_q[$];      // pairs buffered, in order
   logic           m_ph;        // 0: next enabled slot is A
   logic           m_run;       // stream established since last disable
   logic [W-1:0]   m_hold;
   logic [W-1:0]   e_data;
   logic           e_sel, e_frame, e_uf;
   logic           acc;

   // scoreboard for loopback
   logic [2*W-1:0] exp_q[$];

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ph = 1'b0; m_run = 1'b0; m_hold = '0;
      e_data = '0; e_sel = 1'b0; e_frame = 1'b0; e_uf = 1'b0;
   endtask

   // One clock: predict from current inputs, advance, compare.
   task automatic tick();
      logic           set_uf;
      logic [2*W-1:0] p;
      chk("ready", 32'(ready_o), 32'(m_q.size() < D));
      acc    = valid && (m_q.size() < D);
      set_uf = 1'b0;
      if (!ce) begin
         e_data = '0; e_sel = 1'b0; e_frame = 1'b0; m_ph = 1'b0; m_run = 1'b0;
      end else if (!m_ph) begin
         e_sel = 1'b0; e_frame = 1'b1; m_ph = 1'b1;
         if (m_q.size() > 0) begin
            p = m_q.pop_front();
            e_data = p[2*W-1:W]; m_hold = p[W-1:0]; m_run = 1'b1;
         end else begin
            e_data = '0; m_hold = '0;
            if (m_run) set_uf = 1'b1;
         end
      end else begin
         e_data = m_hold; e_sel = 1'b1; e_frame = 1'b0; m_ph = 1'b0;
      end
      if (clr)    e_uf = 1'b0;
      if (set_uf) e_uf = 1'b1;
      if (acc) m_q.push_back({a, b});
      @(posedge clk);
      #1;
      chk("data",  32'(data_o),      32'(e_data));
      chk("sel",   32'(sel_o),       32'(e_sel));
      chk("frame", 32'(frame_o),     32'(e_frame));
      chk("uf",    32'(underflow_o), 32'(e_uf));
      chk("level", 32'(level_o),     32'(m_q.size()));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_sent, n_rx, budget;
      logic [W-1:0] rx_a;
      logic [2*W-1:0] ep;

      rst_n = 1'b0; ce = 1'b0; valid = 1'b0; clr = 1'b0; a = '0; b = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data",  32'(data_o), 0);
      chk("rst_uf",    32'(underflow_o), 0);
      chk("rst_level", 32'(level_o), 0);
      chk("rst_ready", 32'(ready_o), 1);
      @(negedge clk) rst_n = 1'b1;

      // Reset then stream two pairs
      valid = 1'b1; a = 12'h123; b = 12'hFFB; tick();
      a = 12'h7FF; b = 12'h800; tick();
      valid = 1'b0; ce = 1'b1;
      tick(); chk("t1_a0", 32'(data_o), 32'h123); chk("t1_f0", 32'(frame_o), 1);
      tick(); chk("t1_b0", 32'(data_o), 32'hFFB); chk("t1_s0", 32'(sel_o), 1);
      tick(); chk("t1_a1", 32'(data_o), 32'h7FF); chk("t1_f1", 32'(frame_o), 1);
      tick(); chk("t1_b1", 32'(data_o), 32'h800); chk("t1_uf", 32'(underflow_o), 0);
      ce = 1'b0; tick();

      // Fill to full, then a 5th offered pair is refused
      valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         a = W'(16 + i); b = W'(32 + i); tick();
      end
      chk("t2_level4", 32'(level_o), 4);
      chk("t2_full",   32'(ready_o), 0);
      a = 12'hABC; b = 12'hDEF; tick();
      chk("t2_level_hold", 32'(level_o), 4);
      valid = 1'b0; ce = 1'b1; tick();
      chk("t2_first_a", 32'(data_o), 32'd16);
      chk("t2_ready_after_pop", 32'(ready_o), 1);

      // Drain into underflow, then set-vs-clear priority and clear
      for (int i = 0; i < 10; i++) tick();
      chk("t3_uf_sticky", 32'(underflow_o), 1);
      if (m_ph) tick();
      clr = 1'b1; tick();
      chk("t3_set_wins", 32'(underflow_o), 1);
      tick();
      chk("t3_cleared", 32'(underflow_o), 0);
      clr = 1'b0;

      // ce drop at B slot, then re-enable with empty FIFO
      ce = 1'b0; tick();
      valid = 1'b1; a = 12'h055; b = 12'h0AA; tick();
      valid = 1'b0; ce = 1'b1; tick();
      chk("t4_a", 32'(data_o), 32'h055);
      ce = 1'b0; tick();
      chk("t4_drop_data", 32'(data_o), 0);
      chk("t4_drop_sel",  32'(sel_o), 0);
      chk("t4_idle",      32'(dut.state_q), 32'(IDLE));
      ce = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_no_uf", 32'(underflow_o), 0);
      end

      // Asynchronous reset mid-stream with three pairs buffered
      ce = 1'b0; valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         a = W'(12'h300 + i); b = W'(12'h400 + i); tick();
      end
      valid = 1'b0; ce = 1'b1; tick();
      chk("t5_level3", 32'(level_o), 3);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_rst_data",  32'(data_o), 0);
      chk("t5_rst_frame", 32'(frame_o), 0);
      chk("t5_rst_level", 32'(level_o), 0);
      chk("t5_rst_ready", 32'(ready_o), 1);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Loopback: continuous stream of random signed pairs, demuxed by tag
      ce = 1'b0; valid = 1'b1; exp_q.delete(); n_sent = 0;
      a = W'($urandom); b = W'($urandom);
      while (n_sent < D) begin
         tick();
         if (acc) begin
            exp_q.push_back({a, b}); n_sent++;
            a = W'($urandom); b = W'($urandom);
         end
      end
      ce = 1'b1; n_rx = 0; budget = 0; rx_a = '0;
      while (n_rx < 256 && budget < 3000) begin
         valid = (n_sent < 256);
         tick();
         if (acc) begin
            exp_q.push_back({a, b}); n_sent++;
            a = W'($urandom); b = W'($urandom);
         end
         if (frame_o) rx_a = data_o;
         if (sel_o) begin
            if (exp_q.size() == 0) begin
               chk("lb_extra_pair", 32'(n_rx), 32'(n_sent));
            end else begin
               ep = exp_q.pop_front();
               chk("lb_pair", 32'({rx_a, data_o}), 32'(ep));
            end
            n_rx++;
         end
         budget++;
      end
      chk("lb_count", 32'(n_rx), 256);

      // Random enables, pushes and clears against the model
      for (int i = 0; i < 300; i++) begin
         ce    = ($urandom_range(0, 7) != 0);
         valid = ($urandom_range(0, 2) != 0);
         clr   = ($urandom_range(0, 15) == 0);
         a = W'($urandom); b = W'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_adc_chan_mux
